// File: rtl/pc_redirect.sv
// Fetch-PC owner: picks sequential, branch, jump, exception or ERET targets and
// parks a redirect in a one-deep pending slot while the fetch side is not ready.
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_ready,
  input  logic        stall_d,
  input  logic        br_valid_d,
  input  logic        br_taken,
  input  logic [15:0] imm16_d,
  input  logic        j_d,
  input  logic [25:0] jidx_d,
  input  logic        jr_d,
  input  logic [31:0] jr_tgt_d,
  input  logic [31:0] pc_d,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic        redirect,
  output logic        pend
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_pc, pend_pc_nxt, pc_nxt;
  logic [31:0] seq_pc, pc_d_plus4, br_tgt, j_tgt, jr_tgt;
  logic        sel;
  logic [31:0] target;

  assign seq_pc     = pc_f + 32'd4;
  assign pc_d_plus4 = pc_d + 32'd4;
  assign br_tgt     = pc_d_plus4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
  assign j_tgt      = {pc_d_plus4[31:28], jidx_d, 2'b00};
  assign jr_tgt     = {jr_tgt_d[31:2], 2'b00};

  // Exceptions and ERET override stalls; ID control is ignored while stalled or
  // while a redirect is already outstanding.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    sel    = 1'b0;
    target = seq_pc;
    if (exc_req) begin
      sel    = 1'b1;
      target = EXC_VEC;
    end else if (eret_req) begin
      sel    = 1'b1;
      target = epc;
    end else if (state == RUN && !stall_d) begin
      if (jr_d) begin
        sel    = 1'b1;
        target = jr_tgt;
      end else if (j_d) begin
        sel    = 1'b1;
        target = j_tgt;
      end else if (br_valid_d && br_taken) begin
        sel    = 1'b1;
        target = br_tgt;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_f;
    pend_pc_nxt = pend_pc;
    unique case (state)
      RUN: begin
        if (sel) begin
          if (if_ready) begin
            pc_nxt = target;
          end else begin
            pend_pc_nxt = target;
            state_nxt   = PEND;
          end
        end else if (if_ready && !stall_d) begin
          pc_nxt = seq_pc;
        end
      end
      PEND: begin
        // A vector arriving on the release cycle replaces the stored target.
        if (if_ready) begin
          pc_nxt    = sel ? target : pend_pc;
          state_nxt = RUN;
        end else if (sel) begin
          pend_pc_nxt = target;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      pc_f     <= RESET_PC;
      pend_pc  <= 32'd0;
      redirect <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      pc_f     <= pc_nxt;
      pend_pc  <= pend_pc_nxt;
      redirect <= sel;
    end
  end

  assign pend = (state == PEND);

endmodule

// File: tb/tb_pc_redirect.sv
// Self-checking bench for pc_redirect: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_pc_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_ready, stall_d, br_valid_d, br_taken, j_d, jr_d, exc_req, eret_req;
  logic [15:0] imm16_d;
  logic [25:0] jidx_d;
  logic [31:0] jr_tgt_d, pc_d, epc;
  logic [31:0] pc_f;
  logic        redirect, pend;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_pend_pc;
  logic        m_pend, m_redirect;

  pc_redirect dut (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .stall_d(stall_d),
    .br_valid_d(br_valid_d), .br_taken(br_taken), .imm16_d(imm16_d),
    .j_d(j_d), .jidx_d(jidx_d), .jr_d(jr_d), .jr_tgt_d(jr_tgt_d), .pc_d(pc_d),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc_f(pc_f), .redirect(redirect), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall_d = 0; br_valid_d = 0; br_taken = 0; imm16_d = 0; j_d = 0; jidx_d = 0;
    jr_d = 0; jr_tgt_d = 0; pc_d = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_pend = 0; m_pend_pc = 0; m_redirect = 0;
  endtask

  // Highest-priority redirect request visible this cycle, from the target rules.
  task automatic pick(output logic v, output logic [31:0] t);
    logic [31:0] off;
    off = {{16{imm16_d[15]}}, imm16_d} * 4;
    v = 1; t = 0;
    if (exc_req)                          t = 32'h0000_4180;
    else if (eret_req)                    t = epc;
    else if (m_pend || stall_d)           v = 0;
    else if (jr_d)                        t = jr_tgt_d & ~32'h3;
    else if (j_d)                         t = ((pc_d + 4) & 32'hF000_0000) | (32'(jidx_d) << 2);
    else if (br_valid_d && br_taken)      t = pc_d + 4 + off;
    else                                  v = 0;
  endtask

  // Advance one clock with current inputs, then compare DUT to model.
  task automatic cycle(input string tag);
    logic        v;
    logic [31:0] t;
    pick(v, t);
    if (m_pend) begin
      if (if_ready) begin
        m_pc   = v ? t : m_pend_pc;
        m_pend = 0;
      end else if (v) m_pend_pc = t;
    end else if (v) begin
      if (if_ready) m_pc = t;
      else begin
        m_pend    = 1;
        m_pend_pc = t;
      end
    end else if (if_ready && !stall_d) m_pc = m_pc + 4;
    m_redirect = v;
    @(posedge clk);
    #1;
    check({tag, ".pc_f"}, pc_f, m_pc);
    check({tag, ".pend"}, 32'(pend), 32'(m_pend));
    check({tag, ".redirect"}, 32'(redirect), 32'(m_redirect));
  endtask

  initial begin
    rst_n = 0; if_ready = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.pc_f", pc_f, 32'h0000_3000);
    check("reset.pend", 32'(pend), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    model_reset();

    // 1: async reset mid-cycle, then sequential fetch
    if_ready = 1;
    cycle("pre"); cycle("pre");
    #2 rst_n = 0;
    #1;
    check("async.pc_f", pc_f, 32'h0000_3000);
    check("async.pend", 32'(pend), 32'd0);
    check("async.redirect", 32'(redirect), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("t1.hold", pc_f, 32'h0000_3004);
    m_pc = 32'h0000_3004;
    cycle("t1a"); check("t1.b", pc_f, 32'h0000_3008);
    cycle("t1b"); check("t1.c", pc_f, 32'h0000_300C);

    // 2: taken backward branch
    pc_d = 32'h0000_3010; imm16_d = 16'hFFFC; br_valid_d = 1; br_taken = 1;
    cycle("t2"); check("t2.tgt", pc_f, 32'h0000_3004); check("t2.redir", 32'(redirect), 32'd1);
    idle();
    cycle("t2b"); check("t2.pulse", 32'(redirect), 32'd0);

    // 3: untaken branch, then stalled jump
    pc_d = 32'h0000_3020; br_valid_d = 1; br_taken = 0;
    cycle("t3a");
    idle(); stall_d = 1; j_d = 1; jidx_d = 26'h0000_100;
    cycle("t3b"); check("t3.held", pc_f, 32'h0000_300C);

    // 4: JR while fetch not ready
    idle(); jr_d = 1; jr_tgt_d = 32'h0000_5003; if_ready = 0;
    cycle("t4a"); check("t4.pend", 32'(pend), 32'd1);
    idle();
    cycle("t4b");
    if_ready = 1;
    cycle("t4c"); check("t4.tgt", pc_f, 32'h0000_5000);

    // 5: exception beats stalled JR; exception overwrites pending target
    exc_req = 1; jr_d = 1; stall_d = 1; jr_tgt_d = 32'h0000_7000;
    cycle("t5a"); check("t5.vec", pc_f, 32'h0000_4180);
    idle(); jr_d = 1; jr_tgt_d = 32'h0000_6000; if_ready = 0;
    cycle("t5b");
    idle(); exc_req = 1;
    cycle("t5c");
    idle(); if_ready = 1;
    cycle("t5d"); check("t5.pendvec", pc_f, 32'h0000_4180);
    j_d = 1; jidx_d = 26'h0000_400; pc_d = 32'h0000_4180; if_ready = 0;
    cycle("t5e");
    idle(); eret_req = 1; epc = 32'h0000_3050; if_ready = 1;
    cycle("t5f"); check("t5.samecyc", pc_f, 32'h0000_3050);

    // 6: ERET, then PC wrap
    idle(); eret_req = 1; epc = 32'h0000_3040;
    cycle("t6a"); check("t6.eret", pc_f, 32'h0000_3040);
    idle(); jr_d = 1; jr_tgt_d = 32'hFFFF_FFFF;
    cycle("t6b"); check("t6.top", pc_f, 32'hFFFF_FFFC);
    idle();
    cycle("t6c"); check("t6.wrap", pc_f, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if_ready   = ($urandom_range(0, 3) != 0);
      stall_d    = ($urandom_range(0, 3) == 0);
      br_valid_d = $urandom_range(0, 1);
      br_taken   = $urandom_range(0, 1);
      j_d        = ($urandom_range(0, 5) == 0);
      jr_d       = ($urandom_range(0, 5) == 0);
      exc_req    = ($urandom_range(0, 15) == 0);
      eret_req   = ($urandom_range(0, 15) == 0);
      imm16_d    = 16'($urandom);
      jidx_d     = 26'($urandom);
      jr_tgt_d   = $urandom;
      pc_d       = $urandom;
      epc        = $urandom;
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
